// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared types and constants for the iterative multiply/divide
//               unit (operation encodings, FSM states, step mode).
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

  // One radix-2 step per operand bit
  localparam int MDU_ITER = 32;

  // Operation encodings as presented on the op port
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    RUN  = 2'd2,
    FIX  = 2'd3
  } mdu_state_e;

  // Which flavour of iteration the shared step datapath performs
  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } mdu_mode_e;

  // Bit 1 of the encoding selects divide
  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  // Bit 0 clear selects the signed variant
  function automatic logic op_is_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One combinational radix-2 iteration. Multiply does a
//               conditional add then shifts {carry,acc,q} right; divide
//               shifts {rem,q} left and performs a restoring trial subtract.
//               Both share a single WIDTH+1 bit adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  mdu_mode_e        mode,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] mag,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic             is_sub;
  logic [WIDTH:0]   opnd_l;
  logic [WIDTH:0]   opnd_r;
  logic [WIDTH:0]   sum;

  // Shared adder: divide subtracts |b| from the left-shifted remainder,
  // multiply adds |a| to the zero-extended accumulator
  always_comb begin
    is_sub = (mode == STEP_DIV);
    opnd_l = is_sub ? {acc, q[WIDTH-1]} : {1'b0, acc};
    opnd_r = {1'b0, mag} ^ {(WIDTH+1){is_sub}};
    sum    = opnd_l + opnd_r + {{WIDTH{1'b0}}, is_sub};
  end

  // Select the next working values for the active mode
  always_comb begin
    acc_nxt = acc;
    q_nxt   = q;
    if (is_sub) begin
      // The shifted remainder is below 2*|b|, so the trial difference fits
      // in WIDTH+1 signed bits and its top bit is a reliable sign
      if (!sum[WIDTH]) begin
        acc_nxt = sum[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = opnd_l[WIDTH-1:0];
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (q[0]) begin
        acc_nxt = sum[WIDTH:1];
        q_nxt   = {sum[0], q[WIDTH-1:1]};
      end else begin
        acc_nxt = {1'b0, acc[WIDTH-1:1]};
        q_nxt   = {acc[0], q[WIDTH-1:1]};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdu_ctrl
// Description : Iterative MULT/MULTU/DIV/DIVU controller. Owns the HI/LO
//               registers, serves MTHI/MTLO in IDLE and holds busy for the
//               34 cycles of an operation (PREP, WIDTH x RUN, FIX).
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mdu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  mdu_mode_e          step_mode;
  logic [WIDTH-1:0]   step_acc;
  logic [WIDTH-1:0]   step_q;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               res_neg;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic               div_zero;

  assign step_mode = op_is_div(op_q) ? STEP_DIV : STEP_MUL;

  mdu_step #(
    .WIDTH   (WIDTH)
  ) u_step (
    .mode    (step_mode),
    .acc     (acc_q),
    .q       (qr_q),
    .mag     (mag_q),
    .acc_nxt (step_acc),
    .q_nxt   (step_q)
  );

  // Operand magnitudes and final sign correction of the raw result
  always_comb begin
    abs_a    = neg_a_q ? (~a_q + 1'b1) : a_q;
    abs_b    = neg_b_q ? (~b_q + 1'b1) : b_q;
    res_neg  = neg_a_q ^ neg_b_q;
    prod     = {acc_q, qr_q};
    prod_fix = res_neg ? (~prod + 1'b1) : prod;
    quo_fix  = res_neg ? (~qr_q + 1'b1) : qr_q;
    rem_fix  = neg_a_q ? (~acc_q + 1'b1) : acc_q;
    div_zero = (b_q == '0);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    acc_d   = acc_q;
    qr_d    = qr_q;
    mag_d   = mag_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // An accepted start takes priority; a coincident MT write is lost
          op_d    = mdu_op_e'(op);
          a_d     = a;
          b_d     = b;
          neg_a_d = op_is_signed(mdu_op_e'(op)) & a[WIDTH-1];
          neg_b_d = op_is_signed(mdu_op_e'(op)) & b[WIDTH-1];
          state_d = PREP;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end

      PREP: begin
        acc_d   = '0;
        cnt_d   = '0;
        if (op_is_div(op_q)) begin
          qr_d  = abs_a;
          mag_d = abs_b;
        end else begin
          qr_d  = abs_b;
          mag_d = abs_a;
        end
        state_d = RUN;
      end

      RUN: begin
        acc_d = step_acc;
        qr_d  = step_q;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      FIX: begin
        if (!op_is_div(op_q)) begin
          {hi_d, lo_d} = prod_fix;
        end else if (div_zero) begin
          // Divide by zero bypasses sign handling entirely
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      b_q     <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      acc_q   <= '0;
      qr_q    <= '0;
      mag_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      acc_q   <= acc_d;
      qr_q    <= qr_d;
      mag_q   <= mag_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_ctrl
// Description : Scoreboard bench for mdu_ctrl. Expected HI/LO pairs come from
//               plain 64-bit arithmetic and are queued at issue; a monitor
//               pops one per done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           total = 0;
  int           bad   = 0;
  logic [63:0]  exp_q[$];
  logic [63:0]  mon_exp;
  logic [W-1:0] saved;

  always #5 clk = ~clk;

  mdu_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, expv);
    end
  endtask

  // Reference: HI/LO straight from arithmetic definitions
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, t;
    logic [63:0] p;
    logic [31:0] qq, rr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = '0;
    case (o)
      2'b00: begin t = sx * sy; p = t; end
      2'b01: p = {32'd0, x} * {32'd0, y};
      2'b10: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          t = sx / sy; qq = t[31:0];
          t = sx % sy; rr = t[31:0];
          p = {rr, qq};
        end
      end
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else p = {x % y, x / y};
      end
    endcase
    return p;
  endfunction

  // Scoreboard monitor: one expected result per done pulse
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_hilo", {hi, lo}, mon_exp);
      end
    end
  end

  // Drive one start for a cycle; optionally a coincident MTLO
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit with_mt);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    lo_we = with_mt;
    wdata = 32'hDEAD_BEEF;
    exp_q.push_back(ref_model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    lo_we = 1'b0;
  endtask

  // Count remaining busy cycles, then check the done pulse shape
  task automatic wait_done(input string name, input int exp_busy);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check({name, "_busy_cycles"}, n, exp_busy);
    check({name, "_done_pulse"}, done, 1);
    @(negedge clk);
    check({name, "_done_single"}, done, 0);
  endtask

  logic [1:0]  d_op [10] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10};
  logic [31:0] d_a  [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF9, 32'd7,
                             32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'd9, 32'd7};
  logic [31:0] d_b  [10] = '{32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd2, 32'd2,
                             32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFE};

  initial begin
    logic [1:0]  ro;
    logic [31:0] rx, ry;
    int          sel;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations from the plan
    for (int i = 0; i < 10; i++) begin
      issue(d_op[i], d_a[i], d_b[i], 1'b0);
      wait_done("directed", 34);
      if (i == 0) begin
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
      end
      if (i == 3) begin
        check("div_neg7_2_hi", hi, 32'hFFFF_FFFF);
        check("div_neg7_2_lo", lo, 32'hFFFF_FFFD);
      end
    end

    // MT write in the same cycle as an accepted start is dropped
    saved = lo;
    issue(2'b01, 32'd3, 32'd5, 1'b1);
    check("mt_with_start_dropped", lo, saved);
    wait_done("mt_start", 34);

    // Second start and MTHI while busy are ignored
    issue(2'b11, 32'd100, 32'd7, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    saved = hi;
    op = 2'b01; a = 32'd2; b = 32'd2; start = 1'b1;
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    check("mthi_busy_dropped", hi, saved);
    wait_done("ignored_start", 27);
    check("divu_100_7_lo", lo, 32'd14);
    check("divu_100_7_hi", hi, 32'd2);

    // MTLO in idle is visible right after the edge
    saved = hi;
    lo_we = 1'b1; wdata = 32'h55;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo_idle", lo, 32'h55);
    check("mtlo_hi_untouched", hi, saved);
    @(negedge clk);

    // Randomised operations with biased corner operands
    for (int i = 0; i < 40; i++) begin
      ro  = 2'($urandom_range(0, 3));
      rx  = $urandom;
      ry  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ry = 32'd0;
      else if (sel == 1) ry = 32'($urandom_range(1, 15));
      else if (sel == 2) begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
      else if (sel == 3) ry = ~32'($urandom_range(0, 3));
      issue(ro, rx, ry, 1'b0);
      wait_done("random", 34);
    end

    // Asynchronous reset mid-operation
    issue(2'b00, 32'h1234_5678, 32'hFEDC_BA98, 1'b0);
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_late_done_hi", hi, 0);
    issue(2'b01, 32'd6, 32'd7, 1'b0);
    wait_done("after_reset", 34);
    check("after_reset_lo", lo, 32'd42);
    check("after_reset_hi", hi, 32'd0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck design
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide controller for the pipelined MIPS core, executing MULT, MULTU, DIV and DIVU over 34 busy cycles using one radix-2 add/subtract-shift step per cycle. It owns the architectural HI/LO registers, serves MTHI/MTLO writes, and drives `busy` so the pipeline stalls the EX stage while an operation is in flight. It sits beside the single-cycle ALU in EX; HI/LO feed MFHI/MFLO forwarding.

## Interface
- `WIDTH`, 32, operand and HI/LO width; iteration count equals `WIDTH`
- `clk` in 1: the single clock; all state updates on its rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `start` in 1: launch an operation; sampled only in IDLE
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `a` in WIDTH: rs operand (multiplicand/dividend)
- `b` in WIDTH: rt operand (multiplier/divisor)
- `hi_we`, `lo_we` in 1: MTHI/MTLO write strobes
- `wdata` in WIDTH: MTHI/MTLO data
- `busy` out 1: high whenever state ≠ IDLE
- `done` out 1: one-cycle pulse when HI/LO receive a result
- `hi`, `lo` out WIDTH: architectural HI/LO registers

## Operation
- States: IDLE → PREP → RUN (WIDTH cycles, counter 0..WIDTH-1) → FIX → IDLE.
- IDLE: `start`=1 latches `op`, raw `a`, raw `b`, sign flags → PREP. Otherwise, `hi_we`/`lo_we` write `wdata` into HI/LO.
- PREP: the magnitudes |a| and |b| are formed for signed ops, and the raw operands are used for unsigned ops. The working registers are initialised:
  - mult: acc=0, q=|b|.
  - div: rem=0, q=|a|.
- RUN, mult step:
  - If q[0]=1, the 33-bit sum acc+|a| is formed; otherwise acc is kept unchanged.
  - {carry, acc, q} is then shifted right by 1.
- RUN, div step (restoring):
  - {rem, q} is shifted left by 1.
  - trial = rem − |b| at 33 bits.
  - If trial ≥ 0: rem=trial and q[0]=1; otherwise rem is unchanged and q[0]=0.
- FIX: writes HI/LO, pulses `done` next cycle, returns to IDLE.
  - MULT: if sign(a)^sign(b), the 64-bit {acc, q} is negated. HI=upper, LO=lower.
  - DIV: LO=q, negated if sign(a)^sign(b). HI=rem, negated if sign(a)=1.
  - Unsigned ops: no correction.
  - Divide by zero (b=0, DIV or DIVU): sign correction is bypassed. LO=all-ones, HI=raw `a`.
  - 0x80000000 / −1 (DIV): LO=0x80000000, HI=0. This is the natural result; no trap.
- `start` while busy is ignored; no queueing. Issue logic stalls on `busy`.
- `hi_we`/`lo_we` while busy, or in the same cycle as an accepted `start`, are dropped.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, counter=0, `busy`=0, `done`=0, HI=LO=0, all working registers 0. This applies immediately, including mid-operation. The aborted operation leaves no trace.
- Start accepted at edge E0. `busy`=1 from after E0 until E34. HI/LO are updated at E34. `done`=1 for exactly the cycle after E34, coincident with `busy`=0.
- Latency: 34 busy cycles; a new `start` may be accepted in the `done` cycle.
- MTHI/MTLO in IDLE: the new value is visible on `hi`/`lo` the cycle after the edge.
- `done` never asserts for aborted operations or MT writes.

## Structure
- Package `mdu_pkg`:
  - `op` encodings (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`)
  - state enum (IDLE, PREP, RUN, FIX)
  - `MDU_ITER`=32
- Sub-module `mdu_step`: a combinational single iteration.
  - Inputs: mode, acc/rem, q, operand magnitude.
  - Outputs: next acc/rem and next q.
  - Holds the 33-bit adder/subtractor.
- `mdu_ctrl` holds the FSM, counter, operand latches, sign fixup and HI/LO.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `busy` high exactly 34 cycles; `done` a single pulse.
- MULT −3×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000×0x80000000 → HI=0x40000000, LO=0.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5. DIV 0xFFFFFFFB/0 → LO=0xFFFFFFFF, HI=0xFFFFFFFB.
- Second `start` (MULTU 2×2) at RUN cycle 5 of DIVU 100/7 → ignored; final LO=14, HI=2. MTHI 0x1234 while busy is dropped. MTLO 0x55 in IDLE → `lo`=0x55 next cycle.
- `rst_n` pulsed low at RUN cycle 10 of MULT → `busy`=0, `done`=0, HI=LO=0 immediately. A subsequent MULTU 6×7 → LO=42, HI=0.
